// File: rtl/doppler_phase_src.sv
// Phase-word source for the Doppler sin/cos ROM. An accumulator advances on each loaded beat.
// Optional build macro PHASE_DITHER_EN adds LFSR dither to the emitted phase only.
module doppler_phase_src #(
    parameter int unsigned ACC_W   = 32,
    parameter int unsigned PHASE_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic               freq_valid,
    output logic               freq_ready,
    input  logic [ACC_W-1:0]   freq_data,
    input  logic [PHASE_W-1:0] phase_offset,
    input  logic               sync_clr,
    output logic               m_axis_phase_tvalid,
    input  logic               m_axis_phase_tready,
    output logic [PHASE_W-1:0] m_axis_phase_tdata,
    output logic [31:0]        beat_count
);

    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   freq_q, freq_d;
    logic [ACC_W-1:0]   pend_freq_q, pend_freq_d;
    logic               pend_valid_q, pend_valid_d;
    logic               clr_pend_q, clr_pend_d;
    logic               tvalid_q, tvalid_d;
    logic [PHASE_W-1:0] tdata_q, tdata_d;
    logic [31:0]        beat_cnt_q, beat_cnt_d;

    logic               load;
    logic               xfer;
    logic               freq_acc;
    logic [ACC_W-1:0]   f_eff;
    logic [ACC_W-1:0]   a_eff;
    logic [ACC_W-1:0]   a_out;

    assign load     = run & (~tvalid_q | m_axis_phase_tready);
    assign xfer     = tvalid_q & m_axis_phase_tready;
    assign freq_acc = freq_valid & ~pend_valid_q;

    assign f_eff = pend_valid_q ? pend_freq_q : freq_q;
    assign a_eff = (clr_pend_q | sync_clr) ? '0 : acc_q;

`ifdef PHASE_DITHER_EN
    logic [15:0]      lfsr_q, lfsr_d;
    logic [ACC_W-1:0] dith_mask;

    // Dither only spans the bits that truncation throws away.
    assign dith_mask = {ACC_W{1'b1}} >> PHASE_W;
    assign a_out     = a_eff + (ACC_W'(lfsr_q) & dith_mask);

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign a_out = a_eff;
`endif

    always_comb begin
        acc_d        = acc_q;
        freq_d       = freq_q;
        pend_freq_d  = pend_freq_q;
        pend_valid_d = pend_valid_q;
        clr_pend_d   = clr_pend_q;
        tvalid_d     = tvalid_q;
        tdata_d      = tdata_q;
        beat_cnt_d   = beat_cnt_q;

        if (load) begin
            tdata_d      = a_out[ACC_W-1 -: PHASE_W] + phase_offset;
            acc_d        = a_eff + f_eff;
            freq_d       = f_eff;
            pend_valid_d = 1'b0;
            clr_pend_d   = 1'b0;
            tvalid_d     = 1'b1;
        end else begin
            if (xfer) begin
                tvalid_d = 1'b0;
            end
            // A clear that misses a load waits for the next one; the held beat stays intact.
            if (sync_clr) begin
                clr_pend_d = 1'b1;
            end
        end

        // A word accepted alongside a load is only applied at the following load.
        if (freq_acc) begin
            pend_freq_d  = freq_data;
            pend_valid_d = 1'b1;
        end

        if (xfer) begin
            beat_cnt_d = beat_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q        <= '0;
            freq_q       <= '0;
            pend_freq_q  <= '0;
            pend_valid_q <= 1'b0;
            clr_pend_q   <= 1'b0;
            tvalid_q     <= 1'b0;
            tdata_q      <= '0;
            beat_cnt_q   <= '0;
        end else begin
            acc_q        <= acc_d;
            freq_q       <= freq_d;
            pend_freq_q  <= pend_freq_d;
            pend_valid_q <= pend_valid_d;
            clr_pend_q   <= clr_pend_d;
            tvalid_q     <= tvalid_d;
            tdata_q      <= tdata_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    assign freq_ready          = ~pend_valid_q;
    assign m_axis_phase_tvalid = tvalid_q;
    assign m_axis_phase_tdata  = tdata_q;
    assign beat_count          = beat_cnt_q;

endmodule

// File: tb/tb_doppler_phase_src.sv
// Scoreboard bench for doppler_phase_src: stimulus queues hand-computed beats,
// a negedge monitor pops one per accepted beat.
module tb_doppler_phase_src;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic        freq_valid;
    logic        freq_ready;
    logic [31:0] freq_data;
    logic [15:0] phase_offset;
    logic        sync_clr;
    logic        tvalid;
    logic        tready;
    logic [15:0] tdata;
    logic [31:0] beat_count;

    int          checks = 0;
    int          errors = 0;
    int unsigned mon_cnt = 0;
    logic [15:0] exp_q[$];

    doppler_phase_src #(
        .ACC_W   (32),
        .PHASE_W (16)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .run                 (run),
        .freq_valid          (freq_valid),
        .freq_ready          (freq_ready),
        .freq_data           (freq_data),
        .phase_offset        (phase_offset),
        .sync_clr            (sync_clr),
        .m_axis_phase_tvalid (tvalid),
        .m_axis_phase_tready (tready),
        .m_axis_phase_tdata  (tdata),
        .beat_count          (beat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] v);
        exp_q.push_back(v);
    endtask

    // Monitor: every accepted beat must match the next queued value.
    always @(negedge clk) begin
        logic [15:0] e;
        if (!rst_n) begin
            mon_cnt = 0;
        end else if (tvalid && tready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat actual=0x%04h required=none", tdata);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", {16'h0, tdata}, {16'h0, e});
            end
            check("beat_count", beat_count, mon_cnt);
            mon_cnt++;
        end
    end

    initial begin
        rst_n        = 1'b0;
        run          = 1'b0;
        freq_valid   = 1'b0;
        freq_data    = 32'h0;
        phase_offset = 16'h0;
        sync_clr     = 1'b0;
        tready       = 1'b0;
        step();
        step();
        check("rst_tvalid", {31'h0, tvalid}, 32'h0);
        check("rst_tdata", {16'h0, tdata}, 32'h0);
        check("rst_freq_ready", {31'h0, freq_ready}, 32'h1);
        check("rst_beat_count", beat_count, 32'h0);
        rst_n = 1'b1;
        step();

        // Phase A: freq accepted together with the first load -> 0,0,1,2,...
        push(16'h0000); push(16'h0000); push(16'h0001);
        push(16'h0002); push(16'h0003); push(16'h0004);
        run        = 1'b1;
        tready     = 1'b1;
        freq_valid = 1'b1;
        freq_data  = 32'h0001_0000;
        check("pre_run_tvalid", {31'h0, tvalid}, 32'h0);
        step();
        freq_valid = 1'b0;
        check("first_beat_tvalid", {31'h0, tvalid}, 32'h1);
        check("first_beat_tdata", {16'h0, tdata}, 32'h0);
        step(); step(); step();
        tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_tvalid", {31'h0, tvalid}, 32'h1);
            check("stall_tdata", {16'h0, tdata}, 32'h2);
            check("stall_beat_count", beat_count, 32'd3);
        end
        tready = 1'b1;
        step(); step(); step();

        // Phase B: half-turn step with an immediate clear; second request blocked.
        push(16'h0005); push(16'h0006); push(16'h0000);
        push(16'h8000); push(16'h0000); push(16'h8000);
        freq_valid = 1'b1;
        freq_data  = 32'h8000_0000;
        step();
        check("pend_freq_ready", {31'h0, freq_ready}, 32'h0);
        freq_data = 32'h1234_5678;
        sync_clr  = 1'b1;
        step();
        freq_valid = 1'b0;
        sync_clr   = 1'b0;
        check("freq_ready_after_apply", {31'h0, freq_ready}, 32'h1);
        step(); step(); step(); step();

        // Phase C: negative Doppler, tdata counts down.
        push(16'h0000); push(16'h8000); push(16'h0000);
        push(16'hFFFF); push(16'hFFFE);
        freq_valid = 1'b1;
        freq_data  = 32'hFFFF_0000;
        step();
        freq_valid = 1'b0;
        step(); step(); step(); step();

        // Phase D: clear and offset while a beat is held; held beat must not change.
        push(16'hFFFD); push(16'h4000); push(16'h4001);
        tready       = 1'b0;
        sync_clr     = 1'b1;
        freq_valid   = 1'b1;
        freq_data    = 32'h0001_0000;
        phase_offset = 16'h4000;
        step();
        sync_clr   = 1'b0;
        freq_valid = 1'b0;
        check("held_tvalid", {31'h0, tvalid}, 32'h1);
        check("held_tdata", {16'h0, tdata}, 32'h0000_FFFD);
        check("held_freq_ready", {31'h0, freq_ready}, 32'h0);
        step();
        check("held_tdata_2", {16'h0, tdata}, 32'h0000_FFFD);
        tready = 1'b1;
        step(); step(); step();

        // Phase E: asynchronous reset mid-stream.
        check("queue_drained", exp_q.size(), 32'd0);
        check("pre_reset_tvalid", {31'h0, tvalid}, 32'h1);
        check("pre_reset_count", beat_count, 32'd20);
        rst_n = 1'b0;
        #1;
        check("async_rst_tvalid", {31'h0, tvalid}, 32'h0);
        check("async_rst_tdata", {16'h0, tdata}, 32'h0);
        check("async_rst_count", beat_count, 32'h0);
        check("async_rst_freq_ready", {31'h0, freq_ready}, 32'h1);
        run          = 1'b0;
        phase_offset = 16'h0;
        step(); step();
        rst_n = 1'b1;
        push(16'h0000); push(16'h0000); push(16'h0000);
        run = 1'b1;
        step(); step(); step();
        run = 1'b0;
        step();
        check("post_rst_tvalid", {31'h0, tvalid}, 32'h0);
        check("post_rst_count", beat_count, 32'd3);
        check("post_rst_queue", exp_q.size(), 32'd0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/doppler_phase_src.md
Name: doppler_phase_src

Overview:
- AXI-Stream master that generates the phase-word stream consumed by the Doppler sine/cosine ROM (doppler_rom s_axis_phase port).
- 32-bit phase accumulator advanced by a programmable Doppler frequency word; truncated and offset to a 16-bit phase beat.
- Advances only on accepted beats, so phase stays continuous under backpressure.
- Sits between the channel control logic (frequency/offset updates) and the Doppler NCO ROM.

Parameters:
ACC_W, 32, phase accumulator and frequency word width
PHASE_W, 16, output phase width; top PHASE_W bits of the accumulator

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
run  in  1  level; 1 = generate beats
freq_valid  in  1  frequency update request
freq_ready  out  1  frequency update accepted when freq_valid & freq_ready
freq_data  in  ACC_W  new frequency word (unsigned, mod 2^ACC_W; negative Doppler = two's complement)
phase_offset  in  PHASE_W  static phase offset, sampled at each load
sync_clr  in  1  single-cycle pulse; restart phase at next load
m_axis_phase_tvalid  out  1  phase beat valid
m_axis_phase_tready  in  1  downstream ready
m_axis_phase_tdata  out  PHASE_W  phase beat
beat_count  out  32  accepted-beat counter, wraps at 2^32

Behaviour:
- Reset (async assert, sync release): acc=0, freq_reg=0, pend_valid=0, clr_pend=0, m_axis_phase_tvalid=0, m_axis_phase_tdata=0, freq_ready=1, beat_count=0.
- load = run & (~m_axis_phase_tvalid | m_axis_phase_tready). xfer = m_axis_phase_tvalid & m_axis_phase_tready.
- On load:
  - f_eff = pend_valid ? pend_freq : freq_reg.
  - a_eff = clr_pend|sync_clr ? 0 : acc.
  - tdata <= a_eff[ACC_W-1 -: PHASE_W] + phase_offset (mod 2^PHASE_W).
  - acc <= a_eff + f_eff (mod 2^ACC_W).
  - freq_reg <= f_eff; pend_valid <= 0; clr_pend <= 0; tvalid <= 1.
- Not load and xfer (run=0): tvalid <= 0; acc, tdata hold.
- Not load, no xfer: all state holds. AXIS rule: tvalid, once high, stays high with tdata stable until xfer, regardless of run.
- Latency: first beat valid 1 cycle after run rises (tvalid=0 beforehand). Continuous tready=1: one beat per clock.
- Frequency handshake:
  - freq_ready = ~pend_valid.
  - On accept: pend_freq <= freq_data, pend_valid <= 1.
  - Applied as the increment at the next load, so the first beat after application still carries the old phase; step takes effect on the following beat.
  - Accept and load in the same cycle: capture into pend; applied at the following load, not the current one.
- sync_clr:
  - Pulse with load in the same cycle: applies immediately.
  - Otherwise latched in clr_pend until the next load.
  - Next loaded beat has tdata = phase_offset and acc = f_eff.
  - Never alters a beat already presented (tvalid=1, tready=0).
- beat_count increments on every xfer.
- Wrap-around of acc and tdata is silent modular arithmetic; no saturation.
- Reset mid-stream: tvalid drops immediately (async); pending frequency and clear are discarded.

Optional Feature:
- Macro PHASE_DITHER_EN.
- Defined:
  - 16-bit Galois LFSR (poly x^16+x^14+x^13+x^11+1, seed 16'hACE1 at reset) steps on each load.
  - Its low (ACC_W-PHASE_W) bits are added to a_eff before truncation, for tdata only; acc is not dithered.
  - Cuts truncation spurs.
- Undefined: no LFSR; truncation exact as above; bit-exact with the Test Plan values.

Test Plan:
- Reset, freq=0x0001_0000 via handshake, offset=0, run=1, tready=1 -> tdata 0x0000, 0x0000 (old freq 0), 0x0001, 0x0002, ... one per clock; beat_count tracks.
- freq=0x8000_0000 -> tdata toggles 0x0000/0x8000; acc wraps without glitch.
- freq=0x0001_0000, run, tready low 5 cycles mid-stream -> tdata and tvalid frozen; on release the sequence resumes with no skipped or repeated value; beat_count +1 per accepted beat only.
- Second freq_valid while pend_valid=1 -> freq_ready=0, no capture. Freq=0xFFFF_0000 after first -> tdata decrements by 1 per beat (negative Doppler).
- offset=0x4000, sync_clr pulse while tvalid=1, tready=0 -> held beat unchanged. Next beat = 0x4000, then 0x4001.
- rst_n low mid-stream with tvalid=1 -> tvalid, tdata, beat_count =0 same cycle; after release, first beat tdata=0x0000 with freq_reg=0.
